lstm_sequencer: RTL
===================

# lstm_sequencer

Upstream feeder and downstream collector for the single-cell `lstm` datapath. Buffers a streamed input sequence in a small FIFO and issues one sample at a time to the cell, honouring its `ready`. Loads initial hidden/cell state at each sequence start, then waits for the cell result and presents `y`/`C` on a ready/valid output stream. A watchdog flags a cell that never returns `valid`.

## Interface
- `WIDTH`, 16, signed Q8.8 sample/state width (matches cell)
- `FIFO_DEPTH`, 8, input FIFO entries; power of 2, ≥2
- `TIMEOUT`, 31, max cycles in WAIT before error; ≥8

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-high
- `s_data` in WIDTH: input sample x
- `s_first` in 1: sample is first of a sequence
- `s_valid` in 1: input valid
- `s_ready` out 1: input accept (`!fifo_full`)
- `h_init` in WIDTH: initial hidden state, sampled at issue
- `C_init` in WIDTH: initial cell state, sampled at issue
- `cell_ready` in 1: cell `ready`
- `cell_x` out WIDTH: to cell `x_in`
- `cell_x_valid` out 1: to cell `x_in_valid`
- `cell_h` out WIDTH: to cell `h_in`
- `cell_h_valid` out 1: to cell `h_in_valid`
- `cell_C` out WIDTH: to cell `C_in`
- `cell_C_valid` out 1: to cell `C_in_valid`
- `cell_y` in WIDTH: cell `y_out`
- `cell_Cq` in WIDTH: cell `C_out`
- `cell_valid` in 1: cell `valid`
- `m_y` out WIDTH: result hidden output
- `m_C` out WIDTH: result cell state
- `m_first` out 1: result belongs to a first-of-sequence sample
- `m_valid` out 1: result valid
- `m_ready` in 1: downstream accept
- `err` out 1: sticky watchdog timeout
- `err_clr` in 1: clears `err`

## Operation
- FIFO stores {`s_first`, `s_data`}, WIDTH+1 bits, FIFO_DEPTH entries. Push on `s_valid && s_ready`. Push is blocked when full, even on a pop cycle. Pointers wrap modulo FIFO_DEPTH. An occupancy counter of width clog2(FIFO_DEPTH)+1 drives full/empty.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: if FIFO non-empty and `cell_ready`=1, pop the head and go to ISSUE. Otherwise stay.
- ISSUE (exactly 1 cycle): drive `cell_x_valid`=1 with `cell_x`=popped data.
  - If the popped first flag=1: also `cell_h_valid`=`cell_C_valid`=1, with `cell_h`=`h_init`, `cell_C`=`C_init` sampled this cycle.
  - Otherwise the h/C valids stay 0 and the cell uses its internal feedback.
  - Latch the first flag. Go to WAIT. Clear the watchdog counter.
- WAIT: increment the watchdog each cycle.
  - On `cell_valid`=1: capture `cell_y`→`m_y`, `cell_Cq`→`m_C`, and the flag→`m_first`. Set `m_valid`, go to OUT.
  - Else, if the watchdog equals TIMEOUT: set `err`=1 and go to IDLE, producing no result. That sample is dropped.
- OUT: hold `m_*` stable while `m_valid && !m_ready`. On `m_valid && m_ready`: clear `m_valid`, go to IDLE. A new issue never starts in OUT, so at most one sample is in flight.
- `cell_valid` outside WAIT is ignored.
- `err`: set by timeout, cleared by `err_clr`. If both occur in the same cycle, set wins.
- All `cell_*` outputs are registered. Valids are 0 outside ISSUE. Data holds its last value.

## Timing
- Reset (asynchronous assert, synchronous-edge release): state IDLE, FIFO empty, `s_ready`=1, all `cell_*` valids 0, `cell_x`/`cell_h`/`cell_C`=0, `m_valid`=0, `m_y`=`m_C`=0, `m_first`=0, `err`=0, watchdog 0.
- Reset mid-operation aborts all in-flight state. The cell shares `rst`.
- A sample pushed at edge N is poppable in IDLE at cycle N+1. `cell_x_valid` is high in cycle N+2 when `cell_ready`=1.
- Cell `valid` rises 7 cycles after the ISSUE cycle.
- `m_valid` rises the cycle after `cell_valid` is seen.
- Minimum issue-to-issue interval: 10 cycles (1 ISSUE + 7 WAIT + 1 OUT with `m_ready`=1 + 1 IDLE).
- `cell_ready` is sampled only in IDLE. The cell never sees `x_in_valid` while not ready.

## Test plan
- Reset then a single sample with `s_data`=0x0100, `s_first`=1, `h_init`=0, `C_init`=0 -> exactly one ISSUE cycle with `cell_h_valid`=`cell_C_valid`=1. `m_valid` rises 8 cycles after ISSUE with `m_first`=1. Values equal the cell reference model.
- Four-sample sequence (first=1,0,0,0), pushed back-to-back -> FIFO absorbs all 4 (`s_ready` stays 1). h/C valids assert only on issue 1. Outputs arrive in order, spaced ≥10 cycles.
- Push 9 samples with `FIFO_DEPTH`=8 and `cell_ready` held 0 -> `s_ready` drops after the 8th push and the 9th is held. Release `cell_ready` -> all 9 are processed in order and wrap-around is correct.
- Hold `m_ready`=0 for 20 cycles after the first result -> `m_y`/`m_C` stable, no new `cell_x_valid`. Assert `m_ready` -> next ISSUE follows within 2 cycles.
- Stub cell that never asserts `cell_valid` -> `err`=1 exactly TIMEOUT+1 cycles after ISSUE, state returns to IDLE, and the next sample issues. `err_clr` clears `err`.
- Assert `rst` in WAIT with 3 FIFO entries -> all outputs immediately at reset values, FIFO empty, no stale `m_valid` after release.

Source files
------------

// File: rtl/lstm_sequencer_if.sv
// Bundle of the sample input stream, cell-side handshake, result stream and
// error controls of the LSTM sequencer. The master modport is the sequencer's view.
interface lstm_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] s_data;
  logic             s_first;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] h_init;
  logic [WIDTH-1:0] C_init;
  logic             cell_ready;
  logic [WIDTH-1:0] cell_x;
  logic             cell_x_valid;
  logic [WIDTH-1:0] cell_h;
  logic             cell_h_valid;
  logic [WIDTH-1:0] cell_C;
  logic             cell_C_valid;
  logic [WIDTH-1:0] cell_y;
  logic [WIDTH-1:0] cell_Cq;
  logic             cell_valid;
  logic [WIDTH-1:0] m_y;
  logic [WIDTH-1:0] m_C;
  logic             m_first;
  logic             m_valid;
  logic             m_ready;
  logic             err;
  logic             err_clr;

  modport master (
    input  s_data, s_first, s_valid, h_init, C_init, cell_ready,
           cell_y, cell_Cq, cell_valid, m_ready, err_clr,
    output s_ready, cell_x, cell_x_valid, cell_h, cell_h_valid,
           cell_C, cell_C_valid, m_y, m_C, m_first, m_valid, err
  );

  modport slave (
    output s_data, s_first, s_valid, h_init, C_init, cell_ready,
           cell_y, cell_Cq, cell_valid, m_ready, err_clr,
    input  s_ready, cell_x, cell_x_valid, cell_h, cell_h_valid,
           cell_C, cell_C_valid, m_y, m_C, m_first, m_valid, err
  );
endinterface

// File: rtl/lstm_sequencer.sv
// Feeds buffered samples one at a time to a single LSTM cell, collects each
// result onto a ready/valid stream, and flags a cell that never answers.
module lstm_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 31
) (
  input logic              clk,
  input logic              rst,
  lstm_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  typedef struct packed {
    logic             first;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full, fifo_empty, push, pop;
  entry_t           head;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] cell_x_q, cell_x_d, cell_h_q, cell_h_d, cell_C_q, cell_C_d;
  logic             x_valid_q, x_valid_d, hc_valid_q, hc_valid_d;
  logic [WIDTH-1:0] m_y_q, m_y_d, m_C_q, m_C_d;
  logic             m_first_q, m_first_d, m_valid_q, m_valid_d;
  logic             err_q, err_d, err_set;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.s_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the sample store has no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{first: bus.s_first, data: bus.s_data};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    pop        = 1'b0;
    wd_d       = wd_q;
    first_d    = first_q;
    cell_x_d   = cell_x_q;
    cell_h_d   = cell_h_q;
    cell_C_d   = cell_C_q;
    x_valid_d  = 1'b0;
    hc_valid_d = 1'b0;
    m_y_d      = m_y_q;
    m_C_d      = m_C_q;
    m_first_d  = m_first_q;
    m_valid_d  = m_valid_q;
    err_set    = 1'b0;
    case (state_q)
      IDLE: begin
        // Registered cell outputs are loaded here so they are live during ISSUE.
        if (!fifo_empty && bus.cell_ready) begin
          pop       = 1'b1;
          state_d   = ISSUE;
          cell_x_d  = head.data;
          x_valid_d = 1'b1;
          first_d   = head.first;
          if (head.first) begin
            hc_valid_d = 1'b1;
            cell_h_d   = bus.h_init;
            cell_C_d   = bus.C_init;
          end
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.cell_valid) begin
          m_y_d     = bus.cell_y;
          m_C_d     = bus.cell_Cq;
          m_first_d = first_q;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else if (wd_d == WD_W'(TIMEOUT)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      OUT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = err_set || (err_q && !bus.err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      wd_q       <= '0;
      first_q    <= 1'b0;
      cell_x_q   <= '0;
      cell_h_q   <= '0;
      cell_C_q   <= '0;
      x_valid_q  <= 1'b0;
      hc_valid_q <= 1'b0;
      m_y_q      <= '0;
      m_C_q      <= '0;
      m_first_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      wd_q       <= wd_d;
      first_q    <= first_d;
      cell_x_q   <= cell_x_d;
      cell_h_q   <= cell_h_d;
      cell_C_q   <= cell_C_d;
      x_valid_q  <= x_valid_d;
      hc_valid_q <= hc_valid_d;
      m_y_q      <= m_y_d;
      m_C_q      <= m_C_d;
      m_first_q  <= m_first_d;
      m_valid_q  <= m_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.s_ready      = !fifo_full;
  assign bus.cell_x       = cell_x_q;
  assign bus.cell_x_valid = x_valid_q;
  assign bus.cell_h       = cell_h_q;
  assign bus.cell_h_valid = hc_valid_q;
  assign bus.cell_C       = cell_C_q;
  assign bus.cell_C_valid = hc_valid_q;
  assign bus.m_y          = m_y_q;
  assign bus.m_C          = m_C_q;
  assign bus.m_first      = m_first_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.err          = err_q;
endmodule
